// File: rtl/nand_flash_page_ctrl.sv
// nand_flash_page_ctrl
//   Initiator-side page controller for a byte-wide flash array. A host issues
//   page-level READ / PROGRAM / ERASE commands. The controller sequences the
//   per-byte memory accesses and keeps flash semantics: erase writes all-ones,
//   and program can only clear bits (new = old AND data).
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   cmd_valid/ready    command handshake; ready only while idle
//   cmd_op             00 invalid, 01 READ, 10 PROGRAM, 11 ERASE
//   cmd_page           target page index
//   wr_valid/ready     program-data byte handshake
//   wr_data            program-data byte
//   rd_valid, rd_data  read byte stream (no backpressure)
//   busy               high whenever a command is in flight (incl. DONE)
//   done, err          one-cycle completion pulse; err flags an invalid op
//   mem_we, mem_re     memory write / read enables (never both high)
//   mem_addr           byte address {page, offset}
//   mem_wdata          memory write data
//   mem_rdata          memory read data, one cycle after mem_re, else 0
module nand_flash_page_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 16,
  parameter int PAGE_W     = ADDR_W - $clog2(PAGE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [PAGE_W-1:0] cmd_page,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = $clog2(PAGE_BYTES);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STREAM,
    S_RD_DRAIN,
    S_PG_FETCH,
    S_PG_RD,
    S_PG_WR,
    S_ER_WR,
    S_DONE
  } state_t;

  state_t            state;
  logic [OFF_W-1:0]  off;
  logic [PAGE_W-1:0] page_q;
  logic [DATA_W-1:0] wdata_q;

  function automatic logic [ADDR_W-1:0] page_addr(input logic [PAGE_W-1:0] pg,
                                                  input logic [OFF_W-1:0]  o);
    return {pg, o};
  endfunction

  // Write data depends on the array's read data of the same cycle during
  // PG_WR, so it is formed combinationally from registered state. It is
  // forced to zero whenever no write is in progress.
  always_comb begin
    mem_wdata = '0;
    if (mem_we) begin
      if (state == S_ER_WR) mem_wdata = '1;
      else                  mem_wdata = wdata_q & mem_rdata;
    end
  end

  // The array returns read data one cycle after mem_re, which is exactly the
  // cycle rd_valid is raised; gating keeps rd_data at zero otherwise.
  assign rd_data = rd_valid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      off       <= '0;
      page_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            page_q    <= cmd_page;
            off       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              2'b01: begin
                state    <= S_RD_STREAM;
                mem_re   <= 1'b1;
                mem_addr <= page_addr(cmd_page, '0);
              end
              2'b10: begin
                // Address is only driven once the first byte arrives, so it
                // stays put while no access is in progress.
                state    <= S_PG_FETCH;
                wr_ready <= 1'b1;
              end
              2'b11: begin
                state    <= S_ER_WR;
                mem_we   <= 1'b1;
                mem_addr <= page_addr(cmd_page, '0);
              end
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end

        S_RD_STREAM: begin
          rd_valid <= 1'b1;
          if (off == OFF_LAST) begin
            mem_re <= 1'b0;
            off    <= '0;
            state  <= S_RD_DRAIN;
          end else begin
            off      <= off + 1'b1;
            mem_addr <= page_addr(page_q, off + 1'b1);
          end
        end

        // Last read byte is on the bus this cycle; finish next.
        S_RD_DRAIN: begin
          rd_valid <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end

        S_PG_FETCH: begin
          if (wr_valid) begin
            wdata_q  <= wr_data;
            wr_ready <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= page_addr(page_q, off);
            state    <= S_PG_RD;
          end
        end

        S_PG_RD: begin
          mem_re <= 1'b0;
          mem_we <= 1'b1;
          state  <= S_PG_WR;
        end

        S_PG_WR: begin
          mem_we <= 1'b0;
          if (off == OFF_LAST) begin
            off   <= '0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            off      <= off + 1'b1;
            wr_ready <= 1'b1;
            state    <= S_PG_FETCH;
          end
        end

        S_ER_WR: begin
          if (off == OFF_LAST) begin
            mem_we <= 1'b0;
            off    <= '0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            off      <= off + 1'b1;
            mem_addr <= page_addr(page_q, off + 1'b1);
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_flash_page_ctrl.sv
// Testbench for nand_flash_page_ctrl: a behavioural flash array drives
// mem_rdata, while a separate reference array tracks what the page contents
// must be after each command (erase -> all ones, program -> old AND data).
module tb_nand_flash_page_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int P      = 16;
  localparam int PAGE_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [PAGE_W-1:0] cmd_page;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  nand_flash_page_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAGE_BYTES(P), .PAGE_W(PAGE_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_page(cmd_page),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Flash array environment
  logic [7:0] mem [0:255];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_re ? mem[mem_addr] : 8'h00;
  end

  logic [7:0]        ref_mem [0:255];
  logic [7:0]        pdata   [0:P-1];
  logic [ADDR_W-1:0] last_addr;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc_checks(input bit in_op);
    check_eq("we_re_excl", 32'(mem_we & mem_re), 32'(0));
    if (!mem_we && !mem_re) check_eq("addr_hold", 32'(mem_addr), 32'(last_addr));
    else last_addr = mem_addr;
    if (in_op) begin
      check_eq("busy_in_op", 32'(busy), 32'(1));
      check_eq("ready_in_op", 32'(cmd_ready), 32'(0));
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_wr_ready", 32'(wr_ready), 32'(0));
    check_eq("rst_rd_valid", 32'(rd_valid), 32'(0));
    check_eq("rst_rd_data", 32'(rd_data), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_err", 32'(err), 32'(0));
    check_eq("rst_we", 32'(mem_we), 32'(0));
    check_eq("rst_re", 32'(mem_re), 32'(0));
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_wdata", 32'(mem_wdata), 32'(0));
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [3:0] pg);
    @(negedge clk);
    check_eq("idle_ready", 32'(cmd_ready), 32'(1));
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_wr_ready", 32'(wr_ready), 32'(0));
    cyc_checks(1'b0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_page  = pg;
  endtask

  task automatic run_read(input logic [3:0] pg);
    int base;
    base = int'(pg) * P;
    start_cmd(2'b01, pg);
    for (int c = 1; c <= P + 2; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      cyc_checks(1'b1);
      check_eq("rd_re", 32'(mem_re), 32'(c <= P));
      if (c <= P) check_eq("rd_addr", 32'(mem_addr), 32'(base + c - 1));
      check_eq("rd_we", 32'(mem_we), 32'(0));
      check_eq("rd_valid", 32'(rd_valid), 32'(c >= 2 && c <= P + 1));
      if (c >= 2 && c <= P + 1) check_eq("rd_data", 32'(rd_data), 32'(ref_mem[base + c - 2]));
      check_eq("rd_done", 32'(done), 32'(c == P + 2));
      check_eq("rd_err", 32'(err), 32'(0));
    end
  endtask

  // abort_c: first cycle that must show reset outputs (0 = no abort).
  // hold: keep cmd_valid high with a READ of hold_pg queued behind the erase.
  task automatic run_erase(input logic [3:0] pg, input int abort_c,
                           input bit hold, input logic [3:0] hold_pg);
    int base;
    base = int'(pg) * P;
    start_cmd(2'b11, pg);
    for (int c = 1; c <= P + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          cmd_op   = 2'b01;
          cmd_page = hold_pg;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (abort_c != 0 && c == abort_c) begin
        rst = 1'b0;
        check_reset_outputs();
        last_addr = '0;
        for (int k = 0; k < abort_c - 1; k++) ref_mem[base + k] = 8'hFF;
        return;
      end
      cyc_checks(1'b1);
      check_eq("er_we", 32'(mem_we), 32'(c <= P));
      if (c <= P) begin
        check_eq("er_addr", 32'(mem_addr), 32'(base + c - 1));
        check_eq("er_wdata", 32'(mem_wdata), 32'(8'hFF));
      end
      check_eq("er_re", 32'(mem_re), 32'(0));
      check_eq("er_rd_valid", 32'(rd_valid), 32'(0));
      check_eq("er_wr_ready", 32'(wr_ready), 32'(0));
      check_eq("er_done", 32'(done), 32'(c == P + 1));
      check_eq("er_err", 32'(err), 32'(0));
      if (abort_c != 0 && c == abort_c - 1) rst = 1'b1;
    end
    for (int k = 0; k < P; k++) ref_mem[base + k] = 8'hFF;
  endtask

  // Expected per-cycle phase: 0 stalled fetch, 1 fetch, 2 read, 3 write, 4 done
  task automatic run_prog(input logic [3:0] pg, input int stall_k, input int stall_len);
    int ph[$];
    int ix[$];
    int base;
    int p;
    int k;
    base = int'(pg) * P;
    for (int b = 0; b < P; b++) begin
      if (b == stall_k) begin
        for (int s = 0; s < stall_len; s++) begin
          ph.push_back(0);
          ix.push_back(b);
        end
      end
      ph.push_back(1); ix.push_back(b);
      ph.push_back(2); ix.push_back(b);
      ph.push_back(3); ix.push_back(b);
    end
    ph.push_back(4); ix.push_back(0);
    start_cmd(2'b10, pg);
    for (int c = 1; c <= ph.size(); c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      p = ph[c-1];
      k = ix[c-1];
      cyc_checks(1'b1);
      check_eq("pg_wr_ready", 32'(wr_ready), 32'(p <= 1));
      check_eq("pg_re", 32'(mem_re), 32'(p == 2));
      check_eq("pg_we", 32'(mem_we), 32'(p == 3));
      check_eq("pg_rd_valid", 32'(rd_valid), 32'(0));
      check_eq("pg_done", 32'(done), 32'(p == 4));
      check_eq("pg_err", 32'(err), 32'(0));
      if (p == 2 || p == 3) check_eq("pg_addr", 32'(mem_addr), 32'(base + k));
      if (p == 3) begin
        check_eq("pg_wdata", 32'(mem_wdata), 32'(pdata[k] & ref_mem[base + k]));
        ref_mem[base + k] = ref_mem[base + k] & pdata[k];
      end
      if (p == 0) begin
        wr_valid = 1'b0;
      end else if (p == 1) begin
        wr_valid = 1'b1;
        wr_data  = pdata[k];
      end else begin
        wr_valid = 1'b1;               // must be ignored outside fetch
        wr_data  = 8'($urandom);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic run_invalid(input logic [3:0] pg);
    start_cmd(2'b00, pg);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc_checks(1'b1);
    check_eq("inv_done", 32'(done), 32'(1));
    check_eq("inv_err", 32'(err), 32'(1));
    check_eq("inv_we", 32'(mem_we), 32'(0));
    check_eq("inv_re", 32'(mem_re), 32'(0));
    @(negedge clk);
    cyc_checks(1'b0);
    check_eq("inv_done_end", 32'(done), 32'(0));
    check_eq("inv_err_end", 32'(err), 32'(0));
    check_eq("inv_ready_back", 32'(cmd_ready), 32'(1));
  endtask

  initial begin
    int op;
    logic [3:0] pg;
    rst = 1'b1; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_page = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    last_addr = '0;
    check_reset_outputs();

    run_read(4'd0);
    run_erase(4'd3, 0, 1'b0, 4'd0);
    run_read(4'd3);
    for (int i = 0; i < P; i++) pdata[i] = 8'(i);
    run_prog(4'd3, -1, 0);
    run_read(4'd3);
    for (int i = 0; i < P; i++) pdata[i] = 8'hFF;
    pdata[0] = 8'hF0;
    run_prog(4'd3, -1, 0);
    run_read(4'd3);

    run_erase(4'd7, 0, 1'b0, 4'd0);
    for (int i = 0; i < P; i++) pdata[i] = 8'($urandom);
    run_prog(4'd7, 4, 5);
    run_read(4'd7);

    run_erase(4'd5, 6, 1'b0, 4'd0);
    for (int a = 16'h50; a < 16'h60; a++) check_eq("abort_mem", 32'(mem[a]), 32'(ref_mem[a]));
    run_read(4'd5);

    run_invalid(4'd2);
    run_erase(4'd9, 0, 1'b1, 4'd3);
    run_read(4'd3);

    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 3));
      pg = 4'($urandom_range(0, 15));
      case (op)
        0: run_invalid(pg);
        1: run_read(pg);
        2: begin
          for (int i = 0; i < P; i++) pdata[i] = 8'($urandom);
          run_prog(pg, int'($urandom_range(0, P - 1)), int'($urandom_range(0, 4)));
        end
        default: run_erase(pg, 0, 1'b0, 4'd0);
      endcase
    end

    for (int a = 0; a < 256; a++) check_eq("final_mem", 32'(mem[a]), 32'(ref_mem[a]));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
